// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: pipe-register write/flush enables for
// load-use, taken-branch and multi-cycle MDU hazards, plus perf counters.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_use_rt_i,
    input  logic             branch_taken_i,
    input  logic             idex_mdu_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             mdu_start_o,
    output logic             mdu_last_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    localparam logic [7:0]       CNT_INIT = 8'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t     state;
    logic [7:0] cnt;
    logic       lu;
    logic       rt_hit;
    logic       mdu_stall;
    logic       br_flush;

    assign rt_hit = ifid_use_rt_i && (idex_rt_i == ifid_rt_i);

    assign lu = idex_memread_i && (idex_rt_i != 5'd0)
             && ((idex_rt_i == ifid_rs_i) || rt_hit);

    // Front end held, EX/MEM gets bubbles while the MDU owns EX.
    assign mdu_stall = (state == RUN && idex_mdu_i)
                    || (state == MDU_WAIT && cnt != 8'd0);

    assign br_flush = (state == RUN) && !idex_mdu_i && branch_taken_i;

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_write_o  = 1'b1;
        exmem_write_o = 1'b1;
        memwb_write_o = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        mdu_start_o   = 1'b0;
        mdu_last_o    = 1'b0;
        unique case (state)
            RUN: begin
                if (idex_mdu_i) begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_write_o  = 1'b0;
                    exmem_flush_o = 1'b1;
                    mdu_start_o   = 1'b1;
                end else if (branch_taken_i) begin
                    ifid_flush_o  = 1'b1;
                    idex_flush_o  = 1'b1;
                end else if (lu) begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_flush_o  = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (mdu_stall) begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_write_o  = 1'b0;
                    exmem_flush_o = 1'b1;
                end else begin
                    mdu_last_o    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy_o = (state == MDU_WAIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (idex_mdu_i) begin
                        state <= MDU_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                MDU_WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Counters saturate so long runs never report a misleadingly small value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!pc_write_o && stall_cnt_o != CNT_MAX) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
            if (br_flush && flush_cnt_o != CNT_MAX) begin
                flush_cnt_o <= flush_cnt_o + CNT_ONE;
            end
        end
    end

endmodule
